// File: rtl/add_pkg.sv
// ----------------------------------------------------------------------------
// add_pkg
// Shared definitions for the pipelined ripple-carry adder/subtractor.
//   op_e           : operation select (ADD adds, SUB subtracts)
//   stage_flags_t  : per-stage carry bookkeeping that travels with a beat
//   chunk_width()  : bits handled by one pipeline stage
//   width_ok()     : legality check for a Bits/Stages pairing
// Nothing here depends on a particular instance's parameters.
// ----------------------------------------------------------------------------
package add_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  // carry   : carry out of the most recently rippled chunk
  // c_msb   : carry into that chunk's top bit (only meaningful after the
  //           last chunk, where it feeds the signed-overflow flag)
  typedef struct packed {
    logic carry;
    logic c_msb;
  } stage_flags_t;

  function automatic int chunk_width(input int bits, input int stages);
    return bits / stages;
  endfunction

  function automatic bit width_ok(input int bits, input int stages);
    return (stages >= 1) && (stages <= bits) && ((bits % stages) == 0);
  endfunction

endpackage

// File: rtl/add_rca_chunk.sv
// ----------------------------------------------------------------------------
// add_rca_chunk
// Purely combinational Chunk-bit ripple-carry adder built from full_adder
// cells. One instance covers one pipeline stage's slice of the operands.
//   a, b      : chunk operands (b already inverted for subtraction)
//   cin       : carry into bit 0 of the chunk
//   sum       : chunk sum
//   cout      : carry out of the chunk's top bit
//   c_msb_in  : carry into the chunk's top bit (for signed overflow)
// ----------------------------------------------------------------------------
module add_rca_chunk #(
  parameter int Chunk = 16
) (
  input  logic [Chunk-1:0] a,
  input  logic [Chunk-1:0] b,
  input  logic             cin,
  output logic [Chunk-1:0] sum,
  output logic             cout,
  output logic             c_msb_in
);

  // c[i] is the carry into bit i; c[Chunk] is the chunk carry-out.
  logic [Chunk:0] c;

  assign c[0] = cin;

  generate
    for (genvar gi = 0; gi < Chunk; gi++) begin : g_fa
      full_adder u_fa (
        .a  (a[gi]),
        .b  (b[gi]),
        .ci (c[gi]),
        .s  (sum[gi]),
        .co (c[gi+1])
      );
    end
  endgenerate

  assign cout     = c[Chunk];
  assign c_msb_in = c[Chunk-1];

endmodule

// File: rtl/full_adder.sv
// ----------------------------------------------------------------------------
// full_adder
// One-bit full adder cell.
//   a, b, ci : addends and carry-in
//   s, co    : sum and carry-out
// ----------------------------------------------------------------------------
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/add_rca_pipe.sv
// ----------------------------------------------------------------------------
// add_rca_pipe
// Pipelined ripple-carry adder/subtractor. A Bits-wide add is split into
// Stages chunks of Bits/Stages bits; stage k ripples chunk k, so a beat
// spends one clock per chunk. Valid/ready handshake with full back-pressure
// on both sides, one beat per cycle when unstalled.
//   clk        : clock, all state on rising edge
//   reset      : asynchronous, active-low reset
//   in_valid   : operand beat present        in_ready  : beat accepted
//   in_a/in_b  : operands                    in_cin    : carry/borrow in
//   in_sub     : 0 = A+B+cin, 1 = A-B-cin
//   out_valid  : result present              out_ready : consumer accepts
//   out_sum    : result (mod 2^Bits)
//   out_carry  : raw MSB carry-out (subtract: 1 = no borrow)
//   out_ovf    : signed two's-complement overflow
// ----------------------------------------------------------------------------
module add_rca_pipe
  import add_pkg::*;
#(
  parameter int Bits   = 64,
  parameter int Stages = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [Bits-1:0] in_a,
  input  logic [Bits-1:0] in_b,
  input  logic            in_cin,
  input  logic            in_sub,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [Bits-1:0] out_sum,
  output logic            out_carry,
  output logic            out_ovf
);

  localparam int Chunk = chunk_width(Bits, Stages);

  generate
    if (!width_ok(Bits, Stages)) begin : g_bad_width
      $error("add_rca_pipe: Bits must be a multiple of Stages and Stages in 1..Bits");
    end
  endgenerate

  // Stage registers. a_q/b_q carry the operands forward so later stages can
  // reach their chunk; sum_q accumulates finished chunks from the bottom up.
  logic [Stages-1:0] v_q;
  logic [Bits-1:0]   a_q   [Stages];
  logic [Bits-1:0]   b_q   [Stages];
  logic [Bits-1:0]   sum_q [Stages];
  stage_flags_t      flg_q [Stages];

  // Next-state payload produced by each stage's chunk adder.
  logic [Bits-1:0]   a_d   [Stages];
  logic [Bits-1:0]   b_d   [Stages];
  logic [Bits-1:0]   sum_d [Stages];
  stage_flags_t      flg_d [Stages];

  // free[k]: stage k may take a new beat this cycle (empty or emptying).
  // free[Stages] stands for the consumer. adv[k]: stage k hands its beat on.
  // ld[k]: stage k captures a beat.
  logic [Stages:0]   free;
  logic [Stages-1:0] adv;
  logic [Stages-1:0] ld;

  op_e op;
  assign op = op_e'(in_sub);

  always_comb begin
    free         = '0;
    adv          = '0;
    ld           = '0;
    free[Stages] = out_ready;
    // Ready ripples back from the output; a full stage frees up only if the
    // stage after it is free in the same cycle.
    for (int k = Stages - 1; k >= 0; k--) begin
      free[k] = !v_q[k] || free[k+1];
    end
    for (int k = 0; k < Stages; k++) begin
      adv[k] = v_q[k] && free[k+1];
    end
    ld[0] = in_valid && free[0];
    for (int k = 1; k < Stages; k++) begin
      ld[k] = adv[k-1];
    end
  end

  assign in_ready = free[0];

  generate
    for (genvar gi = 0; gi < Stages; gi++) begin : g_stage
      logic [Bits-1:0]  a_src;
      logic [Bits-1:0]  b_src;
      logic [Bits-1:0]  s_src;
      logic             c_src;
      logic [Chunk-1:0] chunk_sum;
      logic             chunk_cout;
      logic             chunk_cmsb;

      if (gi == 0) begin : g_head
        // Subtraction as A + ~B + ~borrow_in.
        assign a_src = in_a;
        assign b_src = (op == OP_SUB) ? ~in_b : in_b;
        assign c_src = (op == OP_SUB) ? ~in_cin : in_cin;
        assign s_src = '0;
      end else begin : g_body
        assign a_src = a_q[gi-1];
        assign b_src = b_q[gi-1];
        assign c_src = flg_q[gi-1].carry;
        assign s_src = sum_q[gi-1];
      end

      add_rca_chunk #(
        .Chunk (Chunk)
      ) u_chunk (
        .a        (a_src[gi*Chunk +: Chunk]),
        .b        (b_src[gi*Chunk +: Chunk]),
        .cin      (c_src),
        .sum      (chunk_sum),
        .cout     (chunk_cout),
        .c_msb_in (chunk_cmsb)
      );

      always_comb begin
        sum_d[gi]                   = s_src;
        sum_d[gi][gi*Chunk +: Chunk] = chunk_sum;
      end

      assign a_d[gi]         = a_src;
      assign b_d[gi]         = b_src;
      assign flg_d[gi].carry = chunk_cout;
      assign flg_d[gi].c_msb = chunk_cmsb;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v_q <= '0;
      for (int k = 0; k < Stages; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        sum_q[k] <= '0;
        flg_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < Stages; k++) begin
        // A load wins over a departure: that is the no-bubble pass-through.
        if (ld[k]) begin
          v_q[k] <= 1'b1;
        end else if (adv[k]) begin
          v_q[k] <= 1'b0;
        end
        if (ld[k]) begin
          a_q[k]   <= a_d[k];
          b_q[k]   <= b_d[k];
          sum_q[k] <= sum_d[k];
          flg_q[k] <= flg_d[k];
        end
      end
    end
  end

  assign out_valid = v_q[Stages-1];
  assign out_sum   = sum_q[Stages-1];
  assign out_carry = flg_q[Stages-1].carry;
  assign out_ovf   = flg_q[Stages-1].carry ^ flg_q[Stages-1].c_msb;

endmodule

// File: tb/tb_add_rca_pipe.sv
module tb_add_rca_pipe;

  localparam int BITS   = 64;
  localparam int STAGES = 4;

  logic            clk;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [BITS-1:0] in_a;
  logic [BITS-1:0] in_b;
  logic            in_cin;
  logic            in_sub;
  logic            out_valid;
  logic            out_ready;
  logic [BITS-1:0] out_sum;
  logic            out_carry;
  logic            out_ovf;

  add_rca_pipe #(
    .Bits   (BITS),
    .Stages (STAGES)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_carry (out_carry),
    .out_ovf   (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [BITS-1:0] sum;
    logic            carry;
    logic            ovf;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   retired = 0;

  // Reference: exact integer arithmetic in two extra bits of headroom.
  // Unsigned view gives the carry/borrow, signed view gives overflow.
  function automatic exp_t model(input logic [BITS-1:0] a, input logic [BITS-1:0] b,
                                 input logic cin, input logic sub);
    exp_t        m;
    logic [BITS+1:0] ua, ub, sa, sbv, u, r, c;
    ua  = {2'b00, a};
    ub  = {2'b00, b};
    sa  = {{2{a[BITS-1]}}, a};
    sbv = {{2{b[BITS-1]}}, b};
    c   = {{(BITS+1){1'b0}}, cin};
    if (!sub) begin
      u = ua + ub + c;
      r = sa + sbv + c;
    end else begin
      u = ua - ub - c;
      r = sa - sbv - c;
    end
    m.sum   = u[BITS-1:0];
    m.carry = sub ? !u[BITS+1] : u[BITS];
    m.ovf   = !((r[BITS+1:BITS-1] == 3'b000) || (r[BITS+1:BITS-1] == 3'b111));
    return m;
  endfunction

  task automatic chk(input string nm, input logic [BITS-1:0] act, input logic [BITS-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // One driver cycle: drive at negedge, decide the transfer 1ns later.
  task automatic step(input logic v, input logic [BITS-1:0] a, input logic [BITS-1:0] b,
                      input logic cin, input logic sub, input logic ordy,
                      input exp_t e, output logic acc);
    @(negedge clk);
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    in_cin    = cin;
    in_sub    = sub;
    out_ready = ordy;
    #1;
    acc = in_valid && in_ready;
    if (acc) sb.push_back(e);
  endtask

  task automatic send(input logic [BITS-1:0] a, input logic [BITS-1:0] b,
                      input logic cin, input logic sub, input exp_t e);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 50) begin
      step(1'b1, a, b, cin, sub, 1'b1, e, acc);
      n++;
    end
    chk("send_accept", {63'd0, acc}, 64'd1);
  endtask

  task automatic drain(input int budget);
    logic acc;
    int   n;
    exp_t z;
    z = '0;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, z, acc);
      n++;
    end
    // one extra cycle lets the monitor finish the last pop
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, z, acc);
    chk("drain_empty", BITS'(sb.size()), 64'd0);
  endtask

  // Monitor: pops the scoreboard on every output transfer, and checks that a
  // stalled output neither drops valid nor changes its payload.
  exp_t held;
  logic held_v = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (!reset) begin
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        chk("stall_valid", {63'd0, out_valid}, 64'd1);
        chk("stall_sum", out_sum, held.sum);
        chk("stall_flags", {62'd0, out_carry, out_ovf}, {62'd0, held.carry, held.ovf});
      end
      if (out_valid && out_ready) begin
        held_v = 1'b0;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output actual=%h required=none", out_sum);
        end else begin
          e = sb.pop_front();
          retired++;
          chk("sum", out_sum, e.sum);
          chk("carry", {63'd0, out_carry}, {63'd0, e.carry});
          chk("ovf", {63'd0, out_ovf}, {63'd0, e.ovf});
          $display("beat %0d: sum=%h carry=%0b ovf=%0b (want %h %0b %0b)",
                   retired, out_sum, out_carry, out_ovf, e.sum, e.carry, e.ovf);
        end
      end else if (out_valid) begin
        held_v = 1'b1;
        held   = {out_sum, out_carry, out_ovf};
      end else begin
        held_v = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic            acc;
    logic [BITS-1:0] a, b;
    logic            cin, sub;
    exp_t            e;
    int              sent, cyc, acc_cnt;

    reset     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    in_sub    = 1'b0;
    out_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_sum", out_sum, 64'd0);
    chk("rst_out_flags", {62'd0, out_carry, out_ovf}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

    // 1: 1+2 with exact latency
    e = '{sum: 64'd3, carry: 1'b0, ovf: 1'b0};
    step(1'b1, 64'd1, 64'd2, 1'b0, 1'b0, 1'b1, e, acc);
    chk("t1_accept", {63'd0, acc}, 64'd1);
    for (int i = 1; i <= STAGES; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk("t1_latency", {63'd0, out_valid}, {63'd0, (i == STAGES)});
    end

    // 2: carry ripples across every chunk
    e = '{sum: 64'd0, carry: 1'b1, ovf: 1'b0};
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, e);
    // 3: signed overflow, then a subtraction with borrow
    e = '{sum: 64'h8000_0000_0000_0000, carry: 1'b0, ovf: 1'b1};
    send(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, e);
    e = '{sum: 64'hFFFF_FFFF_FFFF_FFFE, carry: 1'b0, ovf: 1'b0};
    send(64'd5, 64'd7, 1'b0, 1'b1, e);
    drain(50);

    // 4: 16 random beats, random back-pressure
    sent = 0;
    cyc  = 0;
    a = {$urandom, $urandom}; b = {$urandom, $urandom};
    cin = 1'($urandom); sub = 1'($urandom);
    while (sent < 16 && cyc < 400) begin
      step(1'b1, a, b, cin, sub, 1'($urandom_range(0, 1)), model(a, b, cin, sub), acc);
      cyc++;
      if (acc) begin
        sent++;
        a = {$urandom, $urandom};
        b = (sent % 5 == 0) ? ~a : {$urandom, $urandom};
        cin = 1'($urandom); sub = 1'($urandom);
      end
    end
    chk("t4_sent", BITS'(sent), 64'd16);
    drain(200);

    // 5: fill with consumer stalled
    acc_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      a = {$urandom, $urandom}; b = {$urandom, $urandom};
      cin = 1'($urandom); sub = 1'($urandom);
      step(1'b1, a, b, cin, sub, 1'b0, model(a, b, cin, sub), acc);
      if (acc) acc_cnt++;
    end
    chk("t5_fill_count", BITS'(acc_cnt), 64'(STAGES));
    chk("t5_in_ready", {63'd0, in_ready}, 64'd0);
    chk("t5_out_valid", {63'd0, out_valid}, 64'd1);
    drain(50);

    // 6: reset with 3 beats in flight
    for (int i = 0; i < 3; i++) begin
      a = {$urandom, $urandom}; b = {$urandom, $urandom};
      step(1'b1, a, b, 1'b0, 1'b0, 1'b0, model(a, b, 1'b0, 1'b0), acc);
    end
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b0;
    sb.delete();
    #1;
    chk("t6_reset_valid", {63'd0, out_valid}, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, '0, acc);
      chk("t6_no_stale", {63'd0, out_valid}, 64'd0);
    end

    // a beat after the reset still flows normally
    a = {$urandom, $urandom}; b = {$urandom, $urandom};
    send(a, b, 1'b1, 1'b1, model(a, b, 1'b1, 1'b1));
    drain(50);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
